scoreboard_mp: RTL
==================

SCOREBOARD_MP -- requirements
Module: scoreboard_mp

Interface
REQ-001 Parameter NR_ENTRIES, default 8, scoreboard depth; SHALL be a power of two, minimum 4.
REQ-002 Parameter NR_WB_PORTS, default 2, number of functional-unit writeback ports.
REQ-003 Parameter NR_COMMIT_PORTS, default 2, number of in-order commit ports; SHALL be between 1 and NR_ENTRIES.
REQ-004 Parameter XLEN, default 64, result width.
REQ-005 Parameter PAYLOAD_W, default 96, opaque decoded-instruction width; stored and returned unmodified.
REQ-006 Local ID_W = log2(NR_ENTRIES), the transaction-ID width; CNT_W = ID_W+1.
REQ-007 Ports, listed as name direction width meaning:
- clk_i in 1: single clock, rising edge.
- rst_i in 1: asynchronous, active-high reset.
- flush_i in 1: invalidate all entries.
- flush_unissued_i in 1: block new issue.
- issue_valid_i in 1: decoded instruction offered.
- issue_payload_i in PAYLOAD_W: decoded instruction.
- issue_ready_o out 1: issue accepted this cycle when high together with issue_valid_i.
- issue_id_o out ID_W: entry index assigned to the offered instruction.
- wb_valid_i in NR_WB_PORTS: per-port writeback strobe.
- wb_id_i in NR_WB_PORTS*ID_W: target entry.
- wb_result_i in NR_WB_PORTS*XLEN: result.
- wb_ex_i in NR_WB_PORTS: exception flag.
- bmiss_i in 1: branch mispredict resolved.
- bmiss_id_i in ID_W: entry of the mispredicted branch.
- commit_valid_o out NR_COMMIT_PORTS: commit slot k valid.
- commit_payload_o out NR_COMMIT_PORTS*PAYLOAD_W, commit_result_o out NR_COMMIT_PORTS*XLEN, commit_ex_o out NR_COMMIT_PORTS: per-slot entry contents.
- commit_ack_i in NR_COMMIT_PORTS: slot k retired.
- entry_valid_o, entry_done_o out NR_ENTRIES each, entry_result_o out NR_ENTRIES*XLEN: forwarding view of registered state.
- usage_o out CNT_W: occupied entries.

Function
REQ-008 Storage SHALL be a circular buffer with issue and commit pointers of width CNT_W; the MSB is the wrap bit; usage = issue_ptr - commit_ptr, modulo 2^CNT_W.
REQ-009 issue_ready_o SHALL equal (usage < NR_ENTRIES) and not flush_unissued_i and not bmiss_i and not flush_i; same-cycle commit SHALL NOT free space for issue.
REQ-010 On issue handshake: entry[issue_ptr] gets valid=1, done=0, ex=0, payload stored; issue_ptr increments; issue_id_o = issue_ptr[ID_W-1:0].
REQ-011 Writeback on port p, when the target entry is valid: set done=1, store result and ex; registered, visible on entry_* and commit_* next cycle; writeback to an invalid entry SHALL be ignored.
REQ-012 Two ports writing the same ID in one cycle: the lowest-index port SHALL win.
REQ-013 commit_valid_o[k] = entry[commit_ptr+k] valid and done, and commit_valid_o[k-1] for k>0, and (k==0 or ex==0 for that entry); an excepting entry SHALL only appear on slot 0.
REQ-014 Acks SHALL be honoured as a prefix only: the retire count n is the number of leading k with commit_ack_i[k] and commit_valid_o[k]; later acks are ignored.
REQ-015 Retired entries SHALL be cleared to valid=0, done=0; commit_ptr advances by n, wrapping modulo 2^CNT_W.
REQ-016 On bmiss_i: all valid entries strictly younger than bmiss_id_i, up to issue_ptr-1, SHALL be invalidated, and issue_ptr is set to the pointer of bmiss_id_i plus 1 with the wrap bit preserved. Commit and writeback of older entries in the same cycle SHALL proceed.
REQ-017 bmiss_i with bmiss_id_i naming an invalid entry SHALL have no effect.
REQ-018 flush_i SHALL override all other events: every entry is invalidated and both pointers go to 0 next cycle.
REQ-019 entry_* outputs SHALL reflect registered state only; there is no same-cycle writeback bypass.

Reset
REQ-020 While rst_i is high: all entries invalid, pointers 0, usage_o=0, commit_valid_o=0, entry_valid_o=0, issue_id_o=0.
REQ-021 The first cycle after release: issue_ready_o=1 if flush_unissued_i=0.
REQ-022 Reset asserted mid-operation SHALL discard all state immediately, regardless of pending handshakes.

Verification
REQ-023 Fill with NR_ENTRIES=8: 8 issues -> ids 0..7, usage_o=8, and issue_ready_o=0 on the 9th offer even with commit_ack_i[0]=1 that cycle.
REQ-024 Dual commit: entries 0,1 done, ack=2'b11 -> usage decreases by 2; ack=2'b10 -> nothing retires.
REQ-025 Exception: entry 1 done with ex=1, entry 0 done -> commit_valid_o=2'b01; after retiring entry 0, entry 1 appears on slot 0 with commit_ex_o[0]=1.
REQ-026 Wrap plus mispredict: commit_ptr=6, issue_ptr=11 (ids 6,7,0,1,2); bmiss_id_i=7 -> ids 0..2 invalid, issue_ptr=8, usage_o=2, next issue_id_o=0.
REQ-027 Collision: wb ports 0 and 1 both write id 3, with results 0xA and 0xB -> entry_result 3 = 0xA.
REQ-028 flush_i together with issue, writeback, and ack -> next cycle usage_o=0, all entry_valid_o=0.

Source files
------------

// File: rtl/scoreboard_mp.sv
// In-order scoreboard: circular buffer of in-flight instructions with multi-port
// writeback, multi-slot in-order commit, branch-mispredict squash and full flush.
module scoreboard_mp #(
    parameter int NR_ENTRIES      = 8,
    parameter int NR_WB_PORTS     = 2,
    parameter int NR_COMMIT_PORTS = 2,
    parameter int XLEN            = 64,
    parameter int PAYLOAD_W       = 96
) (
    input  logic                                 clk_i,
    input  logic                                 rst_i,
    input  logic                                 flush_i,
    input  logic                                 flush_unissued_i,
    input  logic                                 issue_valid_i,
    input  logic [PAYLOAD_W-1:0]                 issue_payload_i,
    output logic                                 issue_ready_o,
    output logic [$clog2(NR_ENTRIES)-1:0]        issue_id_o,
    input  logic [NR_WB_PORTS-1:0]               wb_valid_i,
    input  logic [NR_WB_PORTS*$clog2(NR_ENTRIES)-1:0] wb_id_i,
    input  logic [NR_WB_PORTS*XLEN-1:0]          wb_result_i,
    input  logic [NR_WB_PORTS-1:0]               wb_ex_i,
    input  logic                                 bmiss_i,
    input  logic [$clog2(NR_ENTRIES)-1:0]        bmiss_id_i,
    output logic [NR_COMMIT_PORTS-1:0]           commit_valid_o,
    output logic [NR_COMMIT_PORTS*PAYLOAD_W-1:0] commit_payload_o,
    output logic [NR_COMMIT_PORTS*XLEN-1:0]      commit_result_o,
    output logic [NR_COMMIT_PORTS-1:0]           commit_ex_o,
    input  logic [NR_COMMIT_PORTS-1:0]           commit_ack_i,
    output logic [NR_ENTRIES-1:0]                entry_valid_o,
    output logic [NR_ENTRIES-1:0]                entry_done_o,
    output logic [NR_ENTRIES*XLEN-1:0]           entry_result_o,
    output logic [$clog2(NR_ENTRIES):0]          usage_o
);
    localparam int ID_W  = $clog2(NR_ENTRIES);
    localparam int CNT_W = ID_W + 1;

    logic [NR_ENTRIES-1:0] valid_q, done_q, ex_q;
    logic [PAYLOAD_W-1:0]  payload_q [NR_ENTRIES];
    logic [XLEN-1:0]       result_q  [NR_ENTRIES];
    logic [CNT_W-1:0]      issue_ptr_q, commit_ptr_q, usage;

    logic                  issue_fire;
    logic [CNT_W-1:0]      retire_n;
    logic                  bmiss_hit;
    logic [ID_W-1:0]       bmiss_off;
    logic [NR_ENTRIES-1:0] kill;
    logic [NR_ENTRIES-1:0] wb_hit;
    logic [NR_ENTRIES-1:0] wb_ex_sel;
    logic [XLEN-1:0]       wb_res_sel [NR_ENTRIES];

    // Handshakes: issue transfers when issue_valid_i && issue_ready_o in the same
    // cycle; commit slot k retires when commit_valid_o[k] && commit_ack_i[k] and
    // every lower slot retires too. Ready never depends on same-cycle retirement.
    assign usage         = issue_ptr_q - commit_ptr_q;
    assign usage_o       = usage;
    assign issue_ready_o = (usage < CNT_W'(NR_ENTRIES)) && !flush_unissued_i && !bmiss_i && !flush_i;
    assign issue_fire    = issue_valid_i && issue_ready_o;
    assign issue_id_o    = issue_ptr_q[ID_W-1:0];

    assign entry_valid_o = valid_q;
    assign entry_done_o  = done_q;

    always_comb begin
        entry_result_o = '0;
        for (int i = 0; i < NR_ENTRIES; i++) begin
            entry_result_o[i*XLEN +: XLEN] = result_q[i];
        end
    end

    // Commit window: the valid chain stops at the first not-done entry and keeps
    // any excepting entry off every slot but slot 0.
    always_comb begin
        logic            prev;
        logic            still;
        logic [ID_W-1:0] idx;
        commit_valid_o   = '0;
        commit_payload_o = '0;
        commit_result_o  = '0;
        commit_ex_o      = '0;
        retire_n         = '0;
        prev             = 1'b1;
        still            = 1'b1;
        idx              = '0;
        for (int k = 0; k < NR_COMMIT_PORTS; k++) begin
            idx = commit_ptr_q[ID_W-1:0] + ID_W'(k);
            commit_valid_o[k] = valid_q[idx] && done_q[idx] && prev && ((k == 0) || !ex_q[idx]);
            prev = commit_valid_o[k];
            commit_payload_o[k*PAYLOAD_W +: PAYLOAD_W] = payload_q[idx];
            commit_result_o[k*XLEN +: XLEN]            = result_q[idx];
            commit_ex_o[k]                             = ex_q[idx];
            if (still && commit_valid_o[k] && commit_ack_i[k]) begin
                retire_n = retire_n + CNT_W'(1);
            end else begin
                still = 1'b0;
            end
        end
    end

    // Squash: age is measured as offset from the commit pointer, so the window
    // comparison stays correct across the wrap.
    always_comb begin
        logic [ID_W-1:0] off;
        off       = '0;
        bmiss_hit = bmiss_i && valid_q[bmiss_id_i];
        bmiss_off = bmiss_id_i - commit_ptr_q[ID_W-1:0];
        kill      = '0;
        for (int i = 0; i < NR_ENTRIES; i++) begin
            off     = ID_W'(i) - commit_ptr_q[ID_W-1:0];
            kill[i] = bmiss_hit && (off > bmiss_off) && ({1'b0, off} < usage);
        end
    end

    // Ports are scanned high to low so the lowest-index port lands last and wins.
    always_comb begin
        wb_hit    = '0;
        wb_ex_sel = '0;
        for (int i = 0; i < NR_ENTRIES; i++) begin
            wb_res_sel[i] = '0;
            for (int p = NR_WB_PORTS - 1; p >= 0; p--) begin
                if (wb_valid_i[p] && (wb_id_i[p*ID_W +: ID_W] == ID_W'(i))) begin
                    wb_hit[i]     = 1'b1;
                    wb_ex_sel[i]  = wb_ex_i[p];
                    wb_res_sel[i] = wb_result_i[p*XLEN +: XLEN];
                end
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q      <= '0;
            done_q       <= '0;
            ex_q         <= '0;
            issue_ptr_q  <= '0;
            commit_ptr_q <= '0;
        end else if (flush_i) begin
            valid_q      <= '0;
            done_q       <= '0;
            ex_q         <= '0;
            issue_ptr_q  <= '0;
            commit_ptr_q <= '0;
        end else begin
            for (int i = 0; i < NR_ENTRIES; i++) begin
                if (wb_hit[i] && valid_q[i]) begin
                    done_q[i] <= 1'b1;
                    ex_q[i]   <= wb_ex_sel[i];
                end
            end
            if (issue_fire) begin
                valid_q[issue_ptr_q[ID_W-1:0]] <= 1'b1;
                done_q[issue_ptr_q[ID_W-1:0]]  <= 1'b0;
                ex_q[issue_ptr_q[ID_W-1:0]]    <= 1'b0;
            end
            for (int k = 0; k < NR_COMMIT_PORTS; k++) begin
                if (CNT_W'(k) < retire_n) begin
                    valid_q[commit_ptr_q[ID_W-1:0] + ID_W'(k)] <= 1'b0;
                    done_q[commit_ptr_q[ID_W-1:0] + ID_W'(k)]  <= 1'b0;
                end
            end
            for (int i = 0; i < NR_ENTRIES; i++) begin
                if (kill[i]) begin
                    valid_q[i] <= 1'b0;
                    done_q[i]  <= 1'b0;
                end
            end
            commit_ptr_q <= commit_ptr_q + retire_n;
            if (bmiss_hit) begin
                issue_ptr_q <= commit_ptr_q + CNT_W'(bmiss_off) + CNT_W'(1);
            end else begin
                issue_ptr_q <= issue_ptr_q + CNT_W'(issue_fire);
            end
        end
    end

    // Data fields carry no reset; they are only observed behind valid/done.
    always_ff @(posedge clk_i) begin
        for (int i = 0; i < NR_ENTRIES; i++) begin
            if (wb_hit[i] && valid_q[i]) begin
                result_q[i] <= wb_res_sel[i];
            end
        end
        if (issue_fire) begin
            payload_q[issue_ptr_q[ID_W-1:0]] <= issue_payload_i;
        end
    end

endmodule
